// File: rtl/imm_extend_pipe.sv
// Pipelined immediate-extension unit (sign / zero / upper / branch-offset)
// behind a valid/ready handshake with a 2-entry elastic output buffer.
module imm_extend_pipe #(
   parameter int unsigned IN_W     = 16,
   parameter int unsigned OUT_W    = 32,
   parameter int unsigned BR_SHIFT = 2,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             clk_40,
   input  logic             rst_n_40,
   input  logic             in_valid_40,
   output logic             in_ready_40,
   input  logic [IN_W-1:0]  in_imm_40,
   input  logic [1:0]       in_mode_40,
   output logic             out_valid_40,
   input  logic             out_ready_40,
   output logic [OUT_W-1:0] out_data_40,
   output logic [CNT_W-1:0] xfer_cnt_40
);

   localparam int unsigned EXT_W = OUT_W - IN_W;

   localparam logic [1:0] MODE_SIGN  = 2'b00;
   localparam logic [1:0] MODE_ZERO  = 2'b01;
   localparam logic [1:0] MODE_UPPER = 2'b10;

   logic [OUT_W-1:0] sext;
   logic [OUT_W-1:0] zext;
   logic [OUT_W-1:0] ext_word;

   logic             skid_valid;
   logic [OUT_W-1:0] skid_data;

   logic             drain;
   logic             accept;
   logic             xfer;

   logic             out_valid_nxt;
   logic [OUT_W-1:0] out_data_nxt;
   logic             skid_valid_nxt;
   logic [OUT_W-1:0] skid_data_nxt;

   // Extension happens before buffering so both entries hold final results.
   always_comb begin
      sext = {{EXT_W{in_imm_40[IN_W-1]}}, in_imm_40};
      zext = {{EXT_W{1'b0}}, in_imm_40};
      case (in_mode_40)
         MODE_SIGN:  ext_word = sext;
         MODE_ZERO:  ext_word = zext;
         MODE_UPPER: ext_word = zext << EXT_W;
         default:    ext_word = sext << BR_SHIFT;
      endcase
   end

   always_comb begin
      drain  = ~out_valid_40 | out_ready_40;
      accept = in_valid_40 & in_ready_40;
      xfer   = out_valid_40 & out_ready_40;
   end

   // Elastic buffer next state: skid entry always drains ahead of new input.
   always_comb begin
      out_valid_nxt  = out_valid_40;
      out_data_nxt   = out_data_40;
      skid_valid_nxt = skid_valid;
      skid_data_nxt  = skid_data;
      if (drain) begin
         if (skid_valid) begin
            out_valid_nxt  = 1'b1;
            out_data_nxt   = skid_data;
            skid_valid_nxt = accept;
            if (accept) begin
               skid_data_nxt = ext_word;
            end
         end else if (accept) begin
            out_valid_nxt = 1'b1;
            out_data_nxt  = ext_word;
         end else begin
            out_valid_nxt = 1'b0;
         end
      end else if (accept) begin
         skid_valid_nxt = 1'b1;
         skid_data_nxt  = ext_word;
      end
   end

   always_ff @(posedge clk_40 or negedge rst_n_40) begin
      if (!rst_n_40) begin
         out_valid_40 <= 1'b0;
         out_data_40  <= '0;
         skid_valid   <= 1'b0;
         skid_data    <= '0;
         in_ready_40  <= 1'b1;
         xfer_cnt_40  <= '0;
      end else begin
         out_valid_40 <= out_valid_nxt;
         out_data_40  <= out_data_nxt;
         skid_valid   <= skid_valid_nxt;
         skid_data    <= skid_data_nxt;
         in_ready_40  <= ~skid_valid_nxt;
         if (xfer) begin
            xfer_cnt_40 <= xfer_cnt_40 + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: occupancy/queue reference model
// checked every cycle, plus directed vectors with literal expectations.
module tb_imm_extend_pipe;

   localparam int IN_W = 16, OUT_W = 32, BR_SHIFT = 2, CNT_W = 8;
   localparam int IN_W8 = 8, OUT_W8 = 16, BR_SHIFT8 = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic              in_valid, in_ready, out_valid, out_ready;
   logic [IN_W-1:0]   in_imm;
   logic [1:0]        in_mode;
   logic [OUT_W-1:0]  out_data;
   logic [CNT_W-1:0]  xfer_cnt;

   logic              in_valid8, in_ready8, out_valid8, out_ready8;
   logic [IN_W8-1:0]  in_imm8;
   logic [1:0]        in_mode8;
   logic [OUT_W8-1:0] out_data8;
   logic [CNT_W-1:0]  xfer_cnt8;

   int n_checks = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .BR_SHIFT(BR_SHIFT), .CNT_W(CNT_W)) dut (
      .clk_40(clk), .rst_n_40(rst_n),
      .in_valid_40(in_valid), .in_ready_40(in_ready),
      .in_imm_40(in_imm), .in_mode_40(in_mode),
      .out_valid_40(out_valid), .out_ready_40(out_ready),
      .out_data_40(out_data), .xfer_cnt_40(xfer_cnt)
   );

   imm_extend_pipe #(.IN_W(IN_W8), .OUT_W(OUT_W8), .BR_SHIFT(BR_SHIFT8), .CNT_W(CNT_W)) dut8 (
      .clk_40(clk), .rst_n_40(rst_n),
      .in_valid_40(in_valid8), .in_ready_40(in_ready8),
      .in_imm_40(in_imm8), .in_mode_40(in_mode8),
      .out_valid_40(out_valid8), .out_ready_40(out_ready8),
      .out_data_40(out_data8), .xfer_cnt_40(xfer_cnt8)
   );

   // Extension rules as plain two's-complement arithmetic on 64-bit values.
   function automatic logic [63:0] model_ext(logic [63:0] imm, int mode, int in_w, int out_w, int br);
      logic [63:0] full, half, mask, neg, r;
      logic        is_neg;
      full   = 64'd1 << in_w;
      half   = full >> 1;
      mask   = (64'd1 << out_w) - 64'd1;
      is_neg = (imm >= half);
      neg    = is_neg ? (imm - full) : imm;
      case (mode)
         0:       r = neg & mask;
         1:       r = imm & mask;
         2:       r = (imm * (64'd1 << (out_w - in_w))) & mask;
         default: r = (neg * (64'd1 << br)) & mask;
      endcase
      return r;
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: queue of buffered results; occupancy gives valid/ready.
   logic [OUT_W-1:0] q[$];
   int unsigned      cnt_m = 0;
   logic [OUT_W-1:0] last_out = '0;

   initial begin
      bit acc, xf;
      forever begin
         @(negedge clk or negedge rst_n);
         if (!rst_n) begin
            q.delete();
            cnt_m    = 0;
            last_out = '0;
            if (clk == 1'b0) begin
               chk("rst_out_valid", 64'(out_valid), 64'd0);
               chk("rst_in_ready",  64'(in_ready),  64'd1);
               chk("rst_xfer_cnt",  64'(xfer_cnt),  64'd0);
               chk("rst_out_data",  64'(out_data),  64'd0);
            end
         end else begin
            chk("mdl_out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("mdl_in_ready",  64'(in_ready),  64'(q.size() < 2));
            chk("mdl_xfer_cnt",  64'(xfer_cnt),  64'(cnt_m % 256));
            chk("mdl_out_data",  64'(out_data),  64'((q.size() > 0) ? q[0] : last_out));
            acc = in_valid && (q.size() < 2);
            xf  = (q.size() > 0) && out_ready;
            if (xf) begin
               last_out = q.pop_front();
               cnt_m++;
            end
            if (acc) q.push_back(OUT_W'(model_ext(64'(in_imm), int'(in_mode), IN_W, OUT_W, BR_SHIFT)));
         end
      end
   end

   logic [15:0] t1_imm [5] = '{16'h8001, 16'h8001, 16'h1234, 16'hFFFF, 16'h0003};
   logic [1:0]  t1_mode[5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
   logic [31:0] t1_exp [5] = '{32'hFFFF8001, 32'h00008001, 32'h12340000, 32'hFFFFFFFC, 32'h0000000C};

   logic [7:0]  t6_imm [3] = '{8'h80, 8'h80, 8'hC0};
   logic [1:0]  t6_mode[3] = '{2'b00, 2'b10, 2'b11};
   logic [15:0] t6_exp [3] = '{16'hFF80, 16'h8000, 16'hFF80};

   initial begin
      int  sent, cyc;
      bit  will_acc;
      in_valid = 1'b0; in_imm = '0; in_mode = '0; out_ready = 1'b1;
      in_valid8 = 1'b0; in_imm8 = '0; in_mode8 = '0; out_ready8 = 1'b1;

      repeat (3) tick();
      rst_n = 1'b1;
      chk("post_rst_valid", 64'(out_valid), 64'd0);
      chk("post_rst_ready", 64'(in_ready), 64'd1);
      tick();

      // Mode vectors, one per cycle, 1-cycle latency.
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_imm = t1_imm[i]; in_mode = t1_mode[i];
         chk("t1_model_pin", model_ext(64'(t1_imm[i]), int'(t1_mode[i]), IN_W, OUT_W, BR_SHIFT), 64'(t1_exp[i]));
         tick();
         chk("t1_valid", 64'(out_valid), 64'd1);
         chk("t1_data", 64'(out_data), 64'(t1_exp[i]));
      end
      in_valid = 1'b0;
      tick();
      chk("t1_empty", 64'(out_valid), 64'd0);

      // Back-pressure: two words fill the buffer, third is held.
      out_ready = 1'b0;
      in_valid = 1'b1; in_mode = 2'b01; in_imm = 16'h000A;
      tick();
      chk("t2_ready_after_a", 64'(in_ready), 64'd1);
      chk("t2_data_a", 64'(out_data), 64'h0000000A);
      in_imm = 16'h000B;
      tick();
      chk("t2_full_ready", 64'(in_ready), 64'd0);
      in_imm = 16'h000C;
      tick();
      chk("t2_stall_data", 64'(out_data), 64'h0000000A);
      tick();
      chk("t2_stall_data2", 64'(out_data), 64'h0000000A);
      chk("t2_stall_ready", 64'(in_ready), 64'd0);
      out_ready = 1'b1;
      tick();
      chk("t2_data_b", 64'(out_data), 64'h0000000B);
      chk("t2_ready_back", 64'(in_ready), 64'd1);
      tick();
      chk("t2_data_c", 64'(out_data), 64'h0000000C);
      in_valid = 1'b0;
      tick();
      chk("t2_empty", 64'(out_valid), 64'd0);

      // Random streaming against the model.
      sent = 0; cyc = 0;
      while (sent < 1000 && cyc < 20000) begin
         out_ready = 1'($urandom % 2);
         if (!in_valid && ($urandom % 4 != 0)) begin
            in_valid = 1'b1;
            in_imm   = 16'($urandom);
            in_mode  = 2'($urandom);
         end
         @(negedge clk);
         will_acc = in_valid && in_ready;
         tick();
         if (will_acc) begin
            sent++;
            in_valid = 1'b0;
         end
         cyc++;
      end
      chk("t3_words_sent", 64'(sent), 64'd1000);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) tick();
      chk("t3_drained", 64'(out_valid), 64'd0);

      // Reset while both entries are full.
      out_ready = 1'b0;
      in_valid = 1'b1; in_mode = 2'b00; in_imm = 16'h0001;
      tick();
      in_imm = 16'h0002;
      tick();
      in_valid = 1'b0;
      chk("t4_full", 64'(in_ready), 64'd0);
      #1 rst_n = 1'b0;
      #1;
      chk("t4_rst_valid", 64'(out_valid), 64'd0);
      chk("t4_rst_ready", 64'(in_ready), 64'd1);
      chk("t4_rst_cnt", 64'(xfer_cnt), 64'd0);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid = 1'b1; in_mode = 2'b11; in_imm = 16'h8001;
      tick();
      in_valid = 1'b0;
      chk("t4_first_valid", 64'(out_valid), 64'd1);
      chk("t4_first_data", 64'(out_data), 64'hFFFE0004);
      tick();

      // Counter wrap after 256 transfers.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int j = 0; j <= 256; j++) begin
         in_valid = (j < 256);
         in_imm   = 16'(j);
         in_mode  = 2'b01;
         tick();
         if (j == 255) chk("t5_cnt_ff", 64'(xfer_cnt), 64'hFF);
         if (j == 256) chk("t5_cnt_wrap", 64'(xfer_cnt), 64'h00);
      end
      in_valid = 1'b0;
      tick();

      // Narrow instance: IN_W=8, OUT_W=16, BR_SHIFT=1.
      for (int i = 0; i < 3; i++) begin
         in_valid8 = 1'b1; in_imm8 = t6_imm[i]; in_mode8 = t6_mode[i];
         chk("t6_model_pin", model_ext(64'(t6_imm[i]), int'(t6_mode[i]), IN_W8, OUT_W8, BR_SHIFT8), 64'(t6_exp[i]));
         tick();
         chk("t6_valid", 64'(out_valid8), 64'd1);
         chk("t6_data", 64'(out_data8), 64'(t6_exp[i]));
      end
      in_valid8 = 1'b0;
      tick();
      chk("t6_empty", 64'(out_valid8), 64'd0);
      chk("t6_cnt", 64'(xfer_cnt8), 64'd3);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
